// File: rtl/data_mem_responder_pkg.sv
// Shared constants and request types for the stalling data-memory responder.
package data_mem_responder_pkg;

    localparam int DMEM_WORD_W = 32;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_BUSY = 2'd1,
        DMEM_DONE = 2'd2
    } dmem_state_e;

    typedef enum logic {
        DMEM_OP_READ  = 1'b0,
        DMEM_OP_WRITE = 1'b1
    } dmem_op_e;

    typedef struct packed {
        dmem_op_e               op;
        logic                   mis;
        logic                   err;
        logic [DMEM_WORD_W-1:0] data;
    } dmem_req_t;

    // ren&wen together resolves to a write but is still flagged as an error.
    function automatic dmem_req_t make_req(input logic ren, input logic wen,
                                           input logic [1:0] low,
                                           input logic [DMEM_WORD_W-1:0] data);
        dmem_req_t r;
        r.op   = wen ? DMEM_OP_WRITE : DMEM_OP_READ;
        r.mis  = (low != 2'b00);
        r.err  = r.mis | (ren & wen);
        r.data = data;
        return r;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/data_mem_responder_dmem_array.sv
// Word RAM: synchronous write, asynchronous read, contents never reset.
module dmem_array
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                   clock,
    input  logic                   we,
    input  logic [DEPTH_LOG2-1:0]  waddr,
    input  logic [DMEM_WORD_W-1:0] wdata,
    input  logic [DEPTH_LOG2-1:0]  raddr,
    output logic [DMEM_WORD_W-1:0] rdata
);

    logic [DMEM_WORD_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clock) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory slave with programmable wait states and a ready pulse.
// Optional statistics counters are built when DMEM_STATS_EN is defined.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        ren,
    input  logic        wen,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        ready,
    output logic        err
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count,
    output logic [31:0] stall_count
`endif
);

    dmem_state_e           state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    dmem_req_t             hold_q, new_req, cur_req;
    logic [DEPTH_LOG2-1:0] hold_idx_q, cur_idx;
    logic                  req, commit, arr_we, rd_ok;
    logic [31:0]           rdata;

    assign req     = ren | wen;
    assign new_req = make_req(ren, wen, addr[1:0], din);

    // With zero wait states the access completes straight out of IDLE,
    // before the holding registers have been loaded.
    assign cur_req = (state_q == DMEM_IDLE) ? new_req : hold_q;
    assign cur_idx = (state_q == DMEM_IDLE) ? addr[DEPTH_LOG2+1:2] : hold_idx_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            DMEM_IDLE: begin
                if (req) begin
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? DMEM_DONE : DMEM_BUSY;
                end
            end
            DMEM_BUSY: begin
                if (cnt_q != 4'd0)
                    cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1)
                    state_d = DMEM_DONE;
            end
            DMEM_DONE: state_d = DMEM_IDLE;
            default:   state_d = DMEM_IDLE;
        endcase
    end

    // Side effects happen only on the edge entering DONE; reset aborts them.
    assign commit = (state_d == DMEM_DONE) && (state_q != DMEM_DONE) && !reset;
    assign arr_we = commit && (cur_req.op == DMEM_OP_WRITE) && !cur_req.mis;
    assign rd_ok  = commit && (cur_req.op == DMEM_OP_READ) && !cur_req.mis;

    dmem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
        .clock (clock),
        .we    (arr_we),
        .waddr (cur_idx),
        .wdata (cur_req.data),
        .raddr (cur_idx),
        .rdata (rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= DMEM_IDLE;
            cnt_q      <= 4'd0;
            dout       <= 32'd0;
            hold_q     <= '0;
            hold_idx_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == DMEM_IDLE && req) begin
                hold_q     <= new_req;
                hold_idx_q <= addr[DEPTH_LOG2+1:2];
            end
            if (rd_ok)
                dout <= rdata;
        end
    end

    assign ready = (state_q == DMEM_DONE);
    assign err   = ready & hold_q.err;

`ifdef DMEM_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_count    <= 32'd0;
            wr_count    <= 32'd0;
            stall_count <= 32'd0;
        end else begin
            if (ready && !hold_q.err) begin
                if (hold_q.op == DMEM_OP_READ)
                    rd_count <= sat_inc(rd_count);
                else
                    wr_count <= sat_inc(wr_count);
            end
            if (state_q == DMEM_BUSY || (state_q == DMEM_IDLE && req))
                stall_count <= sat_inc(stall_count);
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed scoreboard bench: dut0 has WAIT_CYCLES=2, dut1 has WAIT_CYCLES=0.
module tb_data_mem_responder;

    logic        clock = 1'b0;
    logic [1:0]  rst;
    logic [31:0] addr, din;
    logic        ren, wen;
    logic [31:0] dout_o  [2];
    logic        ready_o [2];
    logic        err_o   [2];
`ifdef DMEM_STATS_EN
    logic [31:0] rdc [2], wrc [2], stc [2];
`endif

    int nvec  = 0;
    int nfail = 0;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          lat;
    } exp_t;
    exp_t        sb [$];
    logic [31:0] mdl  [2][256];
    logic [31:0] last [2];

    always #5 clock = ~clock;

    data_mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) u_dut0 (
        .clock (clock), .reset (rst[0]), .addr (addr), .ren (ren), .wen (wen),
        .din (din), .dout (dout_o[0]), .ready (ready_o[0]), .err (err_o[0])
`ifdef DMEM_STATS_EN
        , .rd_count (rdc[0]), .wr_count (wrc[0]), .stall_count (stc[0])
`endif
    );

    data_mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) u_dut1 (
        .clock (clock), .reset (rst[1]), .addr (addr), .ren (ren), .wen (wen),
        .din (din), .dout (dout_o[1]), .ready (ready_o[1]), .err (err_o[1])
`ifdef DMEM_STATS_EN
        , .rd_count (rdc[1]), .wr_count (wrc[1]), .stall_count (stc[1])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int s);
        @(negedge clock);
        rst[s] = 1'b1; ren = 1'b0; wen = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk($sformatf("rst%0d_dout", s),  dout_o[s],  32'd0);
        chk($sformatf("rst%0d_ready", s), 32'(ready_o[s]), 32'd0);
        chk($sformatf("rst%0d_err", s),   32'(err_o[s]),   32'd0);
`ifdef DMEM_STATS_EN
        chk($sformatf("rst%0d_rdc", s), rdc[s], 32'd0);
        chk($sformatf("rst%0d_wrc", s), wrc[s], 32'd0);
        chk($sformatf("rst%0d_stc", s), stc[s], 32'd0);
`endif
        rst[s]  = 1'b0;
        last[s] = 32'd0;
    endtask

    // Model computes expectation at drive time; compared when ready appears.
    task automatic access(input int s, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
        exp_t       x;
        int         n;
        logic [7:0] i;
        logic       mis;
        i   = a[9:2];
        mis = (a[1:0] != 2'b00);
        if (w && !mis)
            mdl[s][i] = d;
        else if (r && !w && !mis)
            last[s] = mdl[s][i];
        x.d   = last[s];
        x.e   = mis | (r & w);
        x.lat = (s == 0) ? 3 : 1;
        sb.push_back(x);
        @(negedge clock);
        ren = r; wen = w; addr = a; din = d;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!ready_o[s] && n < 40);
        ren = 1'b0; wen = 1'b0;
        x = sb.pop_front();
        chk($sformatf("d%0d_lat_%h", s, a),  32'(n), 32'(x.lat));
        chk($sformatf("d%0d_err_%h", s, a),  32'(err_o[s]), 32'(x.e));
        chk($sformatf("d%0d_dout_%h", s, a), dout_o[s], x.d);
        @(negedge clock);
        chk($sformatf("d%0d_rdy_lo_%h", s, a), 32'(ready_o[s]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        rst = 2'b11; ren = 1'b0; wen = 1'b0; addr = '0; din = '0;
        last[0] = '0; last[1] = '0;

        // ---- WAIT_CYCLES=2 ----
        do_reset(0);
        access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0);
        access(0, 1'b0, 1'b1, 32'h13, 32'h55);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0);

        // reset during BUSY aborts the pending write
        access(0, 1'b0, 1'b1, 32'h20, 32'h1234);
        @(negedge clock);
        wen = 1'b1; addr = 32'h20; din = 32'hAAAA;
        @(negedge clock);
        seen = ready_o[0];
        rst[0] = 1'b1; wen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            seen = seen | ready_o[0];
            rst[0] = 1'b0;
        end
        chk("abort_no_ready", 32'(seen), 32'd0);
        chk("abort_dout_rst", dout_o[0], 32'd0);
        last[0] = 32'd0;
        access(0, 1'b1, 1'b0, 32'h20, 32'h0);

        // index wrap and ren&wen collision
        access(0, 1'b0, 1'b1, 32'h400, 32'h77);
        access(0, 1'b1, 1'b0, 32'h0, 32'h0);
        access(0, 1'b1, 1'b1, 32'h8, 32'h9);
        access(0, 1'b1, 1'b0, 32'h8, 32'h0);

`ifdef DMEM_STATS_EN
        do_reset(0);
        access(0, 1'b0, 1'b1, 32'h30, 32'h1);
        access(0, 1'b0, 1'b1, 32'h34, 32'h2);
        access(0, 1'b1, 1'b0, 32'h30, 32'h0);
        access(0, 1'b1, 1'b0, 32'h34, 32'h0);
        access(0, 1'b1, 1'b0, 32'h30, 32'h0);
        chk("stats_rd",    rdc[0], 32'd3);
        chk("stats_wr",    wrc[0], 32'd2);
        chk("stats_stall", stc[0], 32'd15);
        do_reset(0);
`endif

        // ---- WAIT_CYCLES=0 ----
        rst[0] = 1'b1;
        do_reset(1);
        access(1, 1'b0, 1'b1, 32'h0, 32'h1);
        access(1, 1'b0, 1'b1, 32'h4, 32'h2);
        @(negedge clock);
        ren = 1'b1; addr = 32'h0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            chk($sformatf("held_rdy_%0d", k), 32'(ready_o[1]), 32'(k % 2));
        end
        ren = 1'b0;
        last[1] = mdl[1][0];
        @(negedge clock);
        access(1, 1'b1, 1'b0, 32'h0, 32'h0);
        access(1, 1'b1, 1'b0, 32'h4, 32'h0);
        access(1, 1'b1, 1'b0, 32'h0, 32'h0);
        access(1, 1'b1, 1'b0, 32'h4, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
